// File: rtl/ddr_avl_pkg.sv
// Shared types and default widths for the DDR3 user0_avl burst responder.
// Bus widths and the FSM state encoding are defined once here and imported by the other files.
package ddr_avl_pkg;

  localparam int DEF_ADDR_W  = 25;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_BURST_W = 4;
  localparam int DEF_BE_W    = DEF_DATA_W / 8;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RD_LAT   = 3'd3,
    ST_RD_BURST = 3'd4
  } state_t;

endpackage

// File: rtl/ddr_avl_bram.sv
// Simple dual-port synchronous RAM: byte-enable write, 1-cycle registered read.
// On a same-address collision the read returns the data being written (write-first).
module ddr_avl_bram #(
  parameter int AW = 10,
  parameter int DW = 64,
  parameter int BW = DW / 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [BW-1:0] be,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] merged;

  always_comb begin
    merged = mem[waddr];
    for (int b = 0; b < BW; b++)
      if (be[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
  end

  // NOTE: the array has no reset on purpose; contents must survive rst_n and RAMs cannot be cleared in one cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merged;
    rdata <= (we && waddr == raddr) ? merged : mem[raddr];
  end

endmodule

// File: rtl/ddr_avl_burst_responder.sv
// Avalon-MM burst slave that stands in for the DDR3 controller's user0_avl port.
// It emulates calibration with a fixed delay and serves bursts from on-chip RAM with a fixed read latency.
module ddr_avl_burst_responder
  import ddr_avl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BURST_W     = DEF_BURST_W,
  parameter int MEM_AW      = 10,
  parameter int RD_LAT      = 3,
  parameter int INIT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   avl_address,
  input  logic                avl_write,
  input  logic                avl_read,
  input  logic [DATA_W-1:0]   avl_writedata,
  input  logic                avl_beginbursttransfer,
  input  logic [BURST_W-1:0]  avl_burstcount,
  input  logic [DATA_W/8-1:0] avl_byteenable,
  output logic [DATA_W-1:0]   avl_readdata,
  output logic                avl_readdatavalid,
  output logic                avl_waitrequest_n,
  output logic                init_done,
  output logic                err_proto,
  output logic [15:0]         wr_beat_cnt,
  output logic [15:0]         rd_beat_cnt
);

  localparam int BE_W   = DATA_W / 8;
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);

  state_t              state, state_nxt;
  logic [INIT_W-1:0]   init_cnt;
  logic [MEM_AW-1:0]   base, beat_idx, ram_waddr;
  logic [BURST_W-1:0]  beat_left;
  logic [3:0]          lat_cnt;
  logic                ram_we, wr_first, rd_accept, rd_issue, err_set;
  logic [DATA_W-1:0]   ram_rdata;

  // Upper address bits alias by design; the burst marker carries no information beyond burstcount.
  logic unused_ok;
  assign unused_ok = &{1'b0, avl_beginbursttransfer, avl_address[ADDR_W-1:MEM_AW]};

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_waddr = base + beat_idx;
    wr_first  = 1'b0;
    rd_accept = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_INIT: if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if ((avl_write || avl_read) && avl_burstcount == '0) begin
          err_set = 1'b1;
        end else if (avl_write) begin
          ram_we    = 1'b1;
          ram_waddr = avl_address[MEM_AW-1:0];
          wr_first  = 1'b1;
          err_set   = avl_read;
          if (avl_burstcount != BURST_W'(1)) state_nxt = ST_WR_BURST;
        end else if (avl_read) begin
          rd_accept = 1'b1;
          state_nxt = ST_RD_LAT;
        end
      end
      ST_WR_BURST: begin
        err_set = avl_read;
        if (avl_write) begin
          ram_we = 1'b1;
          if (beat_left == BURST_W'(1)) state_nxt = ST_IDLE;
        end
      end
      ST_RD_LAT:   if (lat_cnt == '0) state_nxt = ST_RD_BURST;
      ST_RD_BURST: if (beat_left == BURST_W'(1)) state_nxt = ST_IDLE;
      default:     state_nxt = ST_INIT;
    endcase
  end

  // The RAM address runs one beat ahead of readdatavalid to absorb the registered read.
  assign rd_issue = (state == ST_RD_LAT && lat_cnt == '0) || state == ST_RD_BURST;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      base        <= '0;
      beat_idx    <= '0;
      beat_left   <= '0;
      lat_cnt     <= '0;
      err_proto   <= 1'b0;
      wr_beat_cnt <= '0;
      rd_beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + INIT_W'(1);
      if (wr_first) begin
        base      <= avl_address[MEM_AW-1:0];
        beat_idx  <= MEM_AW'(1);
        beat_left <= avl_burstcount - BURST_W'(1);
      end else if (rd_accept) begin
        base      <= avl_address[MEM_AW-1:0];
        beat_idx  <= '0;
        beat_left <= avl_burstcount;
        lat_cnt   <= 4'(RD_LAT - 1);
      end else begin
        if (ram_we || rd_issue) beat_idx <= beat_idx + MEM_AW'(1);
        if (ram_we || state == ST_RD_BURST) beat_left <= beat_left - BURST_W'(1);
        if (state == ST_RD_LAT && lat_cnt != '0) lat_cnt <= lat_cnt - 4'd1;
      end
      if (err_set) err_proto <= 1'b1;
      if (ram_we) wr_beat_cnt <= wr_beat_cnt + 16'd1;
      if (state == ST_RD_BURST) rd_beat_cnt <= rd_beat_cnt + 16'd1;
    end
  end

  ddr_avl_bram #(.AW(MEM_AW), .DW(DATA_W), .BW(BE_W)) u_bram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (avl_writedata),
    .be    (avl_byteenable),
    .raddr (base + beat_idx),
    .rdata (ram_rdata)
  );

  assign avl_readdatavalid = (state == ST_RD_BURST);
  assign avl_readdata      = avl_readdatavalid ? ram_rdata : '0;
  assign avl_waitrequest_n = (state == ST_IDLE) || (state == ST_WR_BURST);
  assign init_done         = (state != ST_INIT);

endmodule
